// File: rtl/morse_sequencer_if.sv
// Byte-input handshake for morse_sequencer: a byte moves on any cycle where
// in_valid and in_ready are both high; in_valid while in_ready is low drops the byte.
interface morse_sequencer_if;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/morse_sequencer.sv
// ASCII-to-Morse keyer: byte FIFO feeding a unit-timed keying FSM.
// Optional macro MORSE_FARNSWORTH_EN stretches character/word gaps by FARNS units.
module morse_sequencer #(
   parameter int CLK_HZ     = 24_000_000,
   parameter int DOT_MS     = 50,
   parameter int DEPTH_LOG2 = 4,
   parameter int FARNS      = 0
) (
   input  logic             clk_24,
   input  logic             rst,
   morse_sequencer_if.slave in_if,
   output logic             key,
   output logic             busy,
   output logic             char_done,
   output logic             bad_char,
   output logic             overflow,
   output logic [2:0]       o_state
);
   localparam int UNIT_CYCLES = (CLK_HZ / 1000) * DOT_MS;
   localparam int UW          = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int DEPTH       = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
`ifdef MORSE_FARNSWORTH_EN
   localparam int CGAP_UNITS = 3 + FARNS;
   localparam int WGAP_UNITS = 4 + FARNS;
`else
   // FARNS deliberately has no effect on standard spacing
   localparam int CGAP_UNITS = 3 + 0 * FARNS;
   localparam int WGAP_UNITS = 4 + 0 * FARNS;
`endif

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_MARK = 3'd2,
      S_SGAP = 3'd3,
      S_CGAP = 3'd4,
      S_WGAP = 3'd5
   } state_t;

   state_t                r_state, w_next;
   logic [7:0]            r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic [UW-1:0]         r_ucnt;
   logic [7:0]            r_units;
   logic [4:0]            r_code;
   logic [2:0]            r_left;
   logic                  r_key;
   logic                  w_push, w_pop, w_unit_last, w_sup, w_space;
   logic [9:0]            w_dec;
   logic                  w_char_done, w_bad_char;

   // Returns {supported, is_space, length, symbols left-aligned with first symbol in bit 4}.
   function automatic logic [9:0] decode(input logic [7:0] c);
      logic [7:0] u;
      logic [7:0] lk;
      logic       sup;
      u   = ((c >= 8'h61) && (c <= 8'h7a)) ? (c - 8'h20) : c;
      lk  = 8'd0;
      sup = 1'b1;
      case (u)
         8'h41: lk = {3'd2, 5'b00001};  8'h42: lk = {3'd4, 5'b01000};
         8'h43: lk = {3'd4, 5'b01010};  8'h44: lk = {3'd3, 5'b00100};
         8'h45: lk = {3'd1, 5'b00000};  8'h46: lk = {3'd4, 5'b00010};
         8'h47: lk = {3'd3, 5'b00110};  8'h48: lk = {3'd4, 5'b00000};
         8'h49: lk = {3'd2, 5'b00000};  8'h4a: lk = {3'd4, 5'b00111};
         8'h4b: lk = {3'd3, 5'b00101};  8'h4c: lk = {3'd4, 5'b00100};
         8'h4d: lk = {3'd2, 5'b00011};  8'h4e: lk = {3'd2, 5'b00010};
         8'h4f: lk = {3'd3, 5'b00111};  8'h50: lk = {3'd4, 5'b00110};
         8'h51: lk = {3'd4, 5'b01101};  8'h52: lk = {3'd3, 5'b00010};
         8'h53: lk = {3'd3, 5'b00000};  8'h54: lk = {3'd1, 5'b00001};
         8'h55: lk = {3'd3, 5'b00001};  8'h56: lk = {3'd4, 5'b00001};
         8'h57: lk = {3'd3, 5'b00011};  8'h58: lk = {3'd4, 5'b01001};
         8'h59: lk = {3'd4, 5'b01011};  8'h5a: lk = {3'd4, 5'b01100};
         8'h30: lk = {3'd5, 5'b11111};  8'h31: lk = {3'd5, 5'b01111};
         8'h32: lk = {3'd5, 5'b00111};  8'h33: lk = {3'd5, 5'b00011};
         8'h34: lk = {3'd5, 5'b00001};  8'h35: lk = {3'd5, 5'b00000};
         8'h36: lk = {3'd5, 5'b10000};  8'h37: lk = {3'd5, 5'b11000};
         8'h38: lk = {3'd5, 5'b11100};  8'h39: lk = {3'd5, 5'b11110};
         8'h20: lk = 8'd0;
         default: sup = 1'b0;
      endcase
      return {sup, (u == 8'h20), lk[7:5], lk[4:0] << (3'd5 - lk[7:5])};
   endfunction

   assign in_if.in_ready = (r_count != FULL_COUNT);
   assign w_push         = in_if.in_valid && in_if.in_ready;
   assign w_pop          = (r_state == S_LOAD);
   assign w_dec          = decode(r_mem[r_rd_ptr]);
   assign w_sup          = w_dec[9];
   assign w_space        = w_dec[8];
   assign w_unit_last    = (r_ucnt == UW'(UNIT_CYCLES - 1));

   always_ff @(posedge clk_24) begin
      if (w_push) r_mem[r_wr_ptr] <= in_if.in_data;
   end

   always_ff @(posedge clk_24) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
            2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_next      = r_state;
      w_char_done = 1'b0;
      w_bad_char  = 1'b0;
      case (r_state)
         S_IDLE: if (r_count != '0) w_next = S_LOAD;
         S_LOAD: begin
            if (!w_sup) begin
               w_bad_char = 1'b1;
               w_next     = S_IDLE;
            end else if (w_space) begin
               w_next = S_WGAP;
            end else begin
               w_next = S_MARK;
            end
         end
         S_MARK: begin
            if (w_unit_last && (r_units == (r_code[4] ? 8'd2 : 8'd0)))
               w_next = (r_left > 3'd1) ? S_SGAP : S_CGAP;
         end
         S_SGAP: if (w_unit_last) w_next = S_MARK;
         S_CGAP, S_WGAP: begin
            if (w_unit_last && (r_units == ((r_state == S_CGAP) ? 8'(CGAP_UNITS - 1)
                                                                : 8'(WGAP_UNITS - 1)))) begin
               w_char_done = 1'b1;
               w_next      = (r_count != '0) ? S_LOAD : S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Unit timers restart on every state entry so each phase is an exact multiple of a unit.
   always_ff @(posedge clk_24) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ucnt  <= '0;
         r_units <= '0;
         r_code  <= '0;
         r_left  <= '0;
         r_key   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_key   <= (w_next == S_MARK);
         if (w_next != r_state) begin
            r_ucnt  <= '0;
            r_units <= '0;
         end else if (w_unit_last) begin
            r_ucnt  <= '0;
            r_units <= r_units + 8'd1;
         end else begin
            r_ucnt <= r_ucnt + UW'(1);
         end
         if (r_state == S_LOAD) begin
            r_code <= w_dec[4:0];
            r_left <= w_dec[7:5];
         end else if ((r_state == S_MARK) && (w_next != S_MARK)) begin
            r_code <= r_code << 1;
            r_left <= r_left - 3'd1;
         end
      end
   end

   assign key       = r_key;
   assign busy      = (r_state != S_IDLE) || (r_count != '0);
   assign char_done = w_char_done;
   assign bad_char  = w_bad_char;
   assign overflow  = in_if.in_valid && !in_if.in_ready;
   assign o_state   = r_state;
endmodule

// File: tb/tb_morse_sequencer.sv
// Randomized scoreboard bench for morse_sequencer: a timeline model predicts the cycle
// of every key edge and status pulse; a negedge monitor pops and compares them.
module tb_morse_sequencer;
   localparam int CLK_HZ     = 1000;
   localparam int DOT_MS     = 4;
   localparam int DEPTH_LOG2 = 2;
   localparam int FARNS      = 2;
   localparam int UNIT       = (CLK_HZ / 1000) * DOT_MS;
   localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef MORSE_FARNSWORTH_EN
   localparam int GAP_C = (3 + FARNS) * UNIT;
   localparam int GAP_W = (4 + FARNS) * UNIT;
`else
   localparam int GAP_C = 3 * UNIT;
   localparam int GAP_W = 4 * UNIT;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       key, busy, char_done, bad_char, overflow;
   logic [2:0] dbg_state;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   bit         mon_en = 1'b0;
   logic       prev_key = 1'b0;

   logic [31:0] exp_key_q[$];
   logic [31:0] exp_done_q[$];
   logic [31:0] exp_bad_q[$];
   logic [31:0] exp_ovf_q[$];

   // Model state: edge at which the keyer is next free, whether it left a gap, FIFO pop edges.
   int m_end = -100;
   bit m_gap_end = 1'b0;
   int m_pop_q[$];
   int m_last_done = 0;
   int m_last_rise = 0;

   morse_sequencer_if bus ();

   morse_sequencer #(
      .CLK_HZ(CLK_HZ), .DOT_MS(DOT_MS), .DEPTH_LOG2(DEPTH_LOG2), .FARNS(FARNS)
   ) dut (
      .clk_24(clk), .rst(rst), .in_if(bus), .key(key), .busy(busy),
      .char_done(char_done), .bad_char(bad_char), .overflow(overflow), .o_state(dbg_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #600_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic string morse_of(input logic [7:0] c);
      logic [7:0] u;
      u = (c >= "a" && c <= "z") ? c - 8'd32 : c;
      case (u)
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
         "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
         "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
         "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
         "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
         "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
         "8": return "---.."; "9": return "----.";
         " ": return "/";
         default: return "?";
      endcase
   endfunction

   // p is the clock edge on which the byte is offered.
   task automatic model_push(input logic [7:0] c, input int p);
      int    t, r, f, d;
      string pat;
      while (m_pop_q.size() > 0 && m_pop_q[0] <= p - 1) void'(m_pop_q.pop_front());
      if (m_pop_q.size() >= DEPTH) begin
         exp_ovf_q.push_back(32'(p - 1));
         return;
      end
      if (m_gap_end && p <= m_end - 1) t = m_end;
      else t = ((p > m_end) ? p : m_end) + 1;
      m_pop_q.push_back(t + 1);
      pat = morse_of(c);
      if (pat == "?") begin
         exp_bad_q.push_back(32'(t));
         m_end     = t + 1;
         m_gap_end = 1'b0;
      end else if (pat == "/") begin
         m_last_done = t + GAP_W;
         exp_done_q.push_back(32'(m_last_done));
         m_end     = t + 1 + GAP_W;
         m_gap_end = 1'b1;
      end else begin
         f = t + 1;
         r = t + 1;
         for (int i = 0; i < pat.len(); i++) begin
            d = (pat[i] == "-") ? 3 * UNIT : UNIT;
            r = (i == 0) ? t + 1 : f + UNIT;
            if (i == 0) m_last_rise = r;
            f = r + d;
            exp_key_q.push_back(32'(r));
            exp_key_q.push_back(32'(f));
         end
         m_last_done = f + GAP_C - 1;
         exp_done_q.push_back(32'(m_last_done));
         m_end     = f + GAP_C;
         m_gap_end = 1'b1;
      end
   endtask

   // Reset sampled on edge r: nothing scheduled from r onward happens; key falls at r.
   task automatic model_reset(input int r);
      while (exp_key_q.size() > 0 && int'(exp_key_q[$]) >= r) void'(exp_key_q.pop_back());
      while (exp_done_q.size() > 0 && int'(exp_done_q[$]) >= r) void'(exp_done_q.pop_back());
      while (exp_bad_q.size() > 0 && int'(exp_bad_q[$]) >= r) void'(exp_bad_q.pop_back());
      while (exp_ovf_q.size() > 0 && int'(exp_ovf_q[$]) >= r) void'(exp_ovf_q.pop_back());
      exp_key_q.push_back(32'(r));
      m_pop_q.delete();
      m_end     = r;
      m_gap_end = 1'b0;
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pop_cmp(input int kind, input string name);
      logic [31:0] e;
      bit          have;
      have = 1'b0;
      e    = '0;
      case (kind)
         0: if (exp_key_q.size() > 0)  begin have = 1'b1; e = exp_key_q.pop_front();  end
         1: if (exp_done_q.size() > 0) begin have = 1'b1; e = exp_done_q.pop_front(); end
         2: if (exp_bad_q.size() > 0)  begin have = 1'b1; e = exp_bad_q.pop_front();  end
         default: if (exp_ovf_q.size() > 0) begin have = 1'b1; e = exp_ovf_q.pop_front(); end
      endcase
      checks++;
      if (!have) begin
         errors++;
         $display("FAIL %s: unexpected event at cycle %0d, none expected", name, cyc);
      end else if (int'(e) != cyc) begin
         errors++;
         $display("FAIL %s: seen at cycle %0d expected cycle %0d", name, cyc, int'(e));
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (key !== prev_key) pop_cmp(0, "key_edge");
         if (char_done === 1'b1) pop_cmp(1, "char_done");
         if (bad_char === 1'b1) pop_cmp(2, "bad_char");
         if (overflow === 1'b1) pop_cmp(3, "overflow");
      end
      prev_key = key;
   end

   task automatic drive_string(input string s);
      @(posedge clk);
      #1;
      for (int i = 0; i < s.len(); i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = s[i];
         model_push(s[i], cyc + 1);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic settle(input string name);
      while (cyc < m_end + 3) @(negedge clk);
      check_val({name, "_left_key"}, exp_key_q.size(), 0);
      check_val({name, "_left_done"}, exp_done_q.size(), 0);
      check_val({name, "_left_bad"}, exp_bad_q.size() + exp_ovf_q.size(), 0);
      check_val({name, "_idle_busy"}, int'(busy), 0);
   endtask

   initial begin
      logic [7:0] c;
      int         r;
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      m_end = cyc;
      @(negedge clk);
      check_val("rst_key", int'(key), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_char_done", int'(char_done), 0);
      check_val("rst_bad_char", int'(bad_char), 0);
      check_val("rst_overflow", int'(overflow), 0);
      check_val("rst_in_ready", int'(bus.in_ready), 1);
      mon_en = 1'b1;

      drive_string("E");
      while (cyc < m_last_done) @(negedge clk);
      check_val("e_busy_at_done", int'(busy), 1);
      @(negedge clk);
      check_val("e_busy_after_done", int'(busy), 0);
      settle("e");

      drive_string("a");
      settle("lower_a");
      drive_string("A");
      settle("upper_a");

      drive_string("E E");
      settle("e_space_e");

      drive_string("0");
      repeat (6) @(posedge clk);
      drive_string("ABCDE");
      @(negedge clk);
      check_val("full_in_ready", int'(bus.in_ready), 0);
      settle("overflow");

      drive_string("#T");
      settle("bad_then_t");

      drive_string("T");
      while (cyc < m_last_rise + 5) @(posedge clk);
      #1;
      rst = 1'b1;
      r   = cyc + 1;
      model_reset(r);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("midreset_key", int'(key), 0);
      check_val("midreset_busy", int'(busy), 0);
      settle("midreset");

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: c = 8'(8'h41 + $urandom_range(0, 25));
            4, 5:       c = 8'(8'h61 + $urandom_range(0, 25));
            6, 7:       c = 8'(8'h30 + $urandom_range(0, 9));
            8:          c = 8'h20;
            default:    c = 8'($urandom_range(0, 255));
         endcase
         repeat ($urandom_range(0, 40)) @(posedge clk);
         drive_string(string'(c));
      end
      settle("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 24_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter DOT_MS, default 50, dot (unit) duration in ms; UNIT_CYCLES = (CLK_HZ/1000)*DOT_MS, and UNIT_CYCLES >= 2.
REQ-003 SHALL have parameter DEPTH_LOG2, default 4, giving an input FIFO of 2**DEPTH_LOG2 bytes.
REQ-004 SHALL have parameter FARNS, default 0, extra gap units; it is used only under MORSE_FARNSWORTH_EN.
REQ-005 clk_24  in  1  single system clock; all logic is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  byte offered on in_data.
REQ-008 in_data  in  8  ASCII character.
REQ-009 in_ready  out  1  high when the FIFO is not full.
REQ-010 key  out  1  Morse keying level; 1 means tone on.
REQ-011 busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
REQ-012 char_done  out  1  one-cycle pulse when a character's trailing gap completes.
REQ-013 bad_char  out  1  one-cycle pulse when an unsupported character is discarded.
REQ-014 overflow  out  1  one-cycle pulse when in_valid is high while in_ready is low; the byte is dropped.

Function
REQ-015 SHALL push in_data into the FIFO on cycles where in_valid and in_ready are both high; in_ready SHALL derive from the registered count, so a full FIFO refuses a push even in a pop cycle.
REQ-016 SHALL perform a simultaneous push and pop on a non-full, non-empty FIFO with the count unchanged; pointers SHALL wrap modulo 2**DEPTH_LOG2.
REQ-017 SHALL decode an internal table for A-Z, a-z (mapped to upper case), 0-9 and space (0x20), with up to 5 symbols per character (1 = dash); all other bytes are unsupported.
REQ-018 The FSM SHALL have states IDLE, LOAD, MARK, SGAP, CGAP and WGAP.
REQ-019 IDLE to LOAD when the FIFO is non-empty; LOAD pops the byte, decodes it and clears the unit counter.
REQ-020 From LOAD: a supported letter or digit goes to MARK; space goes to WGAP; an unsupported byte pulses bad_char and returns to IDLE without any gap.
REQ-021 Key SHALL rise exactly 2 cycles after the FIFO becomes non-empty in IDLE.
REQ-022 MARK SHALL hold key=1 for exactly 1*UNIT_CYCLES cycles (dot) or 3*UNIT_CYCLES cycles (dash).
REQ-023 After MARK, the FSM SHALL enter SGAP (key=0, 1 unit) if symbols remain, otherwise CGAP.
REQ-024 CGAP SHALL hold key=0 for 3 units (base); WGAP SHALL hold key=0 for 4 units (base), giving 7 units after a preceding letter.
REQ-025 At the end of CGAP or WGAP, the FSM SHALL pulse char_done and enter LOAD if the FIFO is non-empty, else IDLE; consecutive spaces SHALL each add 4 units.
REQ-026 The unit counter SHALL count 0..UNIT_CYCLES-1 and SHALL be cleared on every state entry, so that durations are exact.
REQ-027 key SHALL be registered and SHALL be 1 only in MARK.

Reset
REQ-028 On rst=1, the block SHALL empty the FIFO, set the FSM to IDLE, and clear the counters; on the next edge key, busy, char_done, bad_char and overflow SHALL all be 0.
REQ-029 Reset mid-character SHALL drop key to 0 on the next edge with no trailing gap, and any in-flight push SHALL be discarded.

Configuration
REQ-030 Macro MORSE_FARNSWORTH_EN: when defined, CGAP SHALL last 3+FARNS units and WGAP 4+FARNS units.
REQ-031 Without MORSE_FARNSWORTH_EN, FARNS SHALL be ignored and the gaps SHALL be 3 and 4 units.

Verification (CLK_HZ=1000, DOT_MS=4 so UNIT_CYCLES=4, DEPTH_LOG2=2, FARNS=2)
REQ-032 Push 'E' -> key high 4 cycles starting 2 cycles after the push, then low 12 cycles; char_done pulses once; busy drops on the next cycle.
REQ-033 Push 'a' -> key pattern H4 L4 H12 L12, identical to 'A'.
REQ-034 Push "E E" back-to-back -> H4, L12, L16 (space), H4, L12; three char_done pulses in total.
REQ-035 Push 5 bytes while the FSM is stalled in MARK -> in_ready low after the 4th byte, overflow pulses on the 5th, and only 4 characters are keyed.
REQ-036 Push '#' then 'T' -> bad_char pulses with no gap, then key is high 12 cycles for 'T'.
REQ-037 Assert rst during the dash of 'T' -> key is 0 on the next edge, busy is 0, and no char_done occurs; with MORSE_FARNSWORTH_EN, 'E' gives L20 after the mark.
